// File: rtl/rtc_pkg.sv
// Shared field widths, limits and calendar helpers for the RTC counter
// and the adjust block that feeds it.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 6;
  localparam int DAY_W  = 6;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 14;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [MON_W-1:0] MON_MAX = 4'd12;
  localparam logic [DAY_W-1:0] DAY_MAX = 6'd31;

  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] NOV = 4'd11;

  // Gregorian rule; all operands stay at year width so nothing overflows.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) ||
           (y % 14'd400 == 14'd0);
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational month length lookup: (month, year) -> last valid day.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [MON_W-1:0]  month,
  input  logic [YEAR_W-1:0] year,
  output logic [DAY_W-1:0]  max_day
);

  always_comb begin
    max_day = DAY_MAX;
    if (month == FEB) begin
      max_day = is_leap(year) ? 6'd29 : 6'd28;
    end else if (month == APR || month == JUN || month == SEP || month == NOV) begin
      max_day = 6'd30;
    end
  end

endmodule

// File: rtl/rtc_time_counter.sv
// Calendar/time-of-day counter: advances on a 1 Hz enable, freezes while the
// adjust block holds stop_count, and loads clamped adjust values on release.
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int unsigned HOUR_MODULUS = 24,
  parameter int unsigned YEAR_MAX     = 9999,
  parameter int unsigned RESET_YEAR   = 2024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              stop_count,
  input  logic [HOUR_W-1:0] adj_hour,
  input  logic [MIN_W-1:0]  adj_min,
  input  logic [SEC_W-1:0]  adj_sec,
  input  logic [DAY_W-1:0]  adj_day,
  input  logic [MON_W-1:0]  adj_month,
  input  logic [YEAR_W-1:0] adj_year,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic [YEAR_W-1:0] year,
  output logic              load_done,
  output logic              day_wrap
);

  localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOUR_MODULUS - 1);
  localparam logic [YEAR_W-1:0] YEAR_LAST  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YEAR_RESET = YEAR_W'(RESET_YEAR);

  logic              stop_q;
  logic              load_ev;
  logic [DAY_W-1:0]  cur_max_day;
  logic [DAY_W-1:0]  adj_max_day;
  logic [HOUR_W-1:0] cl_hour;
  logic [MIN_W-1:0]  cl_min;
  logic [SEC_W-1:0]  cl_sec;
  logic [DAY_W-1:0]  cl_day;
  logic [MON_W-1:0]  cl_month;
  logic [YEAR_W-1:0] cl_year;

  assign load_ev = stop_q && !stop_count;

  rtc_days_in_month u_cur_dim (
    .month   (month),
    .year    (year),
    .max_day (cur_max_day)
  );

  // Day clamp depends on the already-clamped month and year.
  rtc_days_in_month u_adj_dim (
    .month   (cl_month),
    .year    (cl_year),
    .max_day (adj_max_day)
  );

  always_comb begin
    cl_hour  = (adj_hour > HOUR_LAST) ? '0 : adj_hour;
    cl_min   = (adj_min > MIN_MAX) ? '0 : adj_min;
    cl_sec   = (adj_sec > SEC_MAX) ? '0 : adj_sec;
    cl_month = (adj_month == '0 || adj_month > MON_MAX) ? 4'd1 : adj_month;
    cl_year  = (adj_year > YEAR_LAST) ? YEAR_LAST : adj_year;
    if (adj_day == '0) begin
      cl_day = 6'd1;
    end else if (adj_day > adj_max_day) begin
      cl_day = adj_max_day;
    end else begin
      cl_day = adj_day;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour      <= '0;
      min       <= '0;
      sec       <= '0;
      day       <= 6'd1;
      month     <= 4'd1;
      year      <= YEAR_RESET;
      load_done <= 1'b0;
      day_wrap  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      day_wrap  <= 1'b0;
      stop_q    <= stop_count;
      if (load_ev) begin
        // A tick landing on the load cycle is intentionally dropped.
        hour      <= cl_hour;
        min       <= cl_min;
        sec       <= cl_sec;
        day       <= cl_day;
        month     <= cl_month;
        year      <= cl_year;
        load_done <= 1'b1;
      end else if (!stop_count && tick_1hz) begin
        if (sec >= SEC_MAX) begin
          sec <= '0;
          if (min >= MIN_MAX) begin
            min <= '0;
            if (hour >= HOUR_LAST) begin
              hour     <= '0;
              day_wrap <= 1'b1;
              if (day >= cur_max_day) begin
                day <= 6'd1;
                if (month >= MON_MAX) begin
                  month <= 4'd1;
                  year  <= (year >= YEAR_LAST) ? '0 : year + 14'd1;
                end else begin
                  month <= month + 4'd1;
                end
              end else begin
                day <= day + 6'd1;
              end
            end else begin
              hour <= hour + 6'd1;
            end
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter: reset, carry chain, leap years,
// load clamping, stop/hold behaviour and reset during load.
module tb_rtc_time_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        stop_count = 1'b0;
  logic [5:0]  adj_hour = '0;
  logic [5:0]  adj_min = '0;
  logic [5:0]  adj_sec = '0;
  logic [5:0]  adj_day = 6'd1;
  logic [3:0]  adj_month = 4'd1;
  logic [13:0] adj_year = 14'd2024;
  logic [5:0]  hour, min, sec, day;
  logic [3:0]  month;
  logic [13:0] year;
  logic        load_done, day_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  rtc_time_counter dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .stop_count (stop_count),
    .adj_hour   (adj_hour),
    .adj_min    (adj_min),
    .adj_sec    (adj_sec),
    .adj_day    (adj_day),
    .adj_month  (adj_month),
    .adj_year   (adj_year),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .day        (day),
    .month      (month),
    .year       (year),
    .load_done  (load_done),
    .day_wrap   (day_wrap)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s,
                          input int d, input int mo, input int y);
    chk({tag, ".hour"},  32'(hour),  32'(h));
    chk({tag, ".min"},   32'(min),   32'(m));
    chk({tag, ".sec"},   32'(sec),   32'(s));
    chk({tag, ".day"},   32'(day),   32'(d));
    chk({tag, ".month"}, 32'(month), 32'(mo));
    chk({tag, ".year"},  32'(year),  32'(y));
  endtask

  task automatic set_adj(input int h, input int m, input int s,
                         input int d, input int mo, input int y);
    adj_hour  = 6'(h);
    adj_min   = 6'(m);
    adj_sec   = 6'(s);
    adj_day   = 6'(d);
    adj_month = 4'(mo);
    adj_year  = 14'(y);
  endtask

  // One-cycle stop pulse; returns just after the load edge.
  task automatic do_load(input int h, input int m, input int s,
                         input int d, input int mo, input int y);
    set_adj(h, m, s, d, mo, y);
    stop_count = 1'b1;
    step();
    stop_count = 1'b0;
    step();
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    // Reset held two cycles
    rst = 1'b1;
    step();
    step();
    chk_time("reset", 0, 0, 0, 1, 1, 2024);
    chk("reset.load_done", 32'(load_done), 32'd0);
    chk("reset.day_wrap", 32'(day_wrap), 32'd0);
    rst = 1'b0;
    step();

    // Full rollover at end of year 9999
    do_load(23, 59, 59, 31, 12, 9999);
    chk_time("load_max", 23, 59, 59, 31, 12, 9999);
    chk("load_max.load_done", 32'(load_done), 32'd1);
    step();
    chk("load_max.load_done_clr", 32'(load_done), 32'd0);
    do_tick();
    chk_time("rollover", 0, 0, 0, 1, 1, 0);
    chk("rollover.day_wrap", 32'(day_wrap), 32'd1);
    step();
    chk("rollover.day_wrap_clr", 32'(day_wrap), 32'd0);

    // Minute/hour carry without day wrap
    do_load(10, 59, 59, 5, 5, 2024);
    do_tick();
    chk_time("hour_carry", 11, 0, 0, 5, 5, 2024);
    chk("hour_carry.day_wrap", 32'(day_wrap), 32'd0);

    // Leap-year handling at end of Feb 28
    do_load(23, 59, 59, 28, 2, 2024);
    do_tick();
    chk_time("leap2024", 0, 0, 0, 29, 2, 2024);
    do_load(23, 59, 59, 28, 2, 2023);
    do_tick();
    chk_time("leap2023", 0, 0, 0, 1, 3, 2023);
    do_load(23, 59, 59, 28, 2, 1900);
    do_tick();
    chk_time("leap1900", 0, 0, 0, 1, 3, 1900);
    do_load(23, 59, 59, 28, 2, 2000);
    do_tick();
    chk_time("leap2000", 0, 0, 0, 29, 2, 2000);
    do_load(23, 59, 59, 29, 2, 2024);
    do_tick();
    chk_time("feb29_2024", 0, 0, 0, 1, 3, 2024);

    // Load clamping
    do_load(10, 20, 63, 31, 4, 2024);
    chk_time("clamp_apr", 10, 20, 0, 30, 4, 2024);
    do_load(5, 6, 7, 15, 0, 2024);
    chk_time("clamp_mon0", 5, 6, 7, 15, 1, 2024);
    do_load(24, 60, 30, 0, 13, 12000);
    chk_time("clamp_misc", 0, 0, 30, 1, 1, 9999);
    do_load(1, 2, 3, 29, 2, 2023);
    chk_time("clamp_feb", 1, 2, 3, 28, 2, 2023);

    // Hold while stopped, then load with a coincident tick
    do_load(12, 0, 0, 15, 6, 2024);
    step();
    set_adj(8, 30, 0, 10, 7, 2025);
    stop_count = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      step();
    end
    chk_time("hold", 12, 0, 0, 15, 6, 2024);
    chk("hold.load_done", 32'(load_done), 32'd0);
    stop_count = 1'b0;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk_time("release", 8, 30, 0, 10, 7, 2025);
    chk("release.load_done", 32'(load_done), 32'd1);
    step();
    chk("release.load_done_once", 32'(load_done), 32'd0);
    do_tick();
    chk_time("after_release", 8, 30, 1, 10, 7, 2025);

    // Reset coincident with tick and stop release
    do_load(0, 0, 0, 1, 1, 2024);
    for (int i = 0; i < 10; i++) begin
      do_tick();
    end
    chk_time("count10", 0, 0, 10, 1, 1, 2024);
    set_adj(7, 7, 7, 7, 7, 2007);
    stop_count = 1'b1;
    step();
    rst = 1'b1;
    tick_1hz = 1'b1;
    stop_count = 1'b0;
    step();
    rst = 1'b0;
    tick_1hz = 1'b0;
    chk_time("mid_rst", 0, 0, 0, 1, 1, 2024);
    chk("mid_rst.load_done", 32'(load_done), 32'd0);
    step();
    chk_time("post_rst", 0, 0, 0, 1, 1, 2024);
    chk("post_rst.load_done", 32'(load_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
